// File: rtl/watch_calendar_core_if.sv
// rtl/watch_calendar_core_if.sv - control, time-set and time-field bundle for watch_calendar_core
// Optional alarm signals exist only when WATCH_ALARM_EN is defined.
interface watch_calendar_core_if #(
    parameter int P_COUNT_BIT = 30,
    parameter int P_YEAR_BIT  = 7
) ();
    logic                   i_run_en;
    logic [P_COUNT_BIT-1:0] i_freq;
    logic                   i_set;
    logic [5:0]             i_set_sec;
    logic [5:0]             i_set_min;
    logic [4:0]             i_set_hour;
    logic [4:0]             i_set_day;
    logic [3:0]             i_set_month;
    logic [P_YEAR_BIT-1:0]  i_set_year;
    logic                   o_sec_tick;
    logic                   o_set_err;
    logic [5:0]             o_sec;
    logic [5:0]             o_min;
    logic [4:0]             o_hour;
    logic [4:0]             o_day;
    logic [3:0]             o_month;
    logic [P_YEAR_BIT-1:0]  o_year;
`ifdef WATCH_ALARM_EN
    logic                   i_alarm_en;
    logic [4:0]             i_alarm_hour;
    logic [5:0]             i_alarm_min;
    logic                   i_alarm_clr;
    logic                   o_alarm;
`endif

    modport master (
        output i_run_en, i_freq, i_set, i_set_sec, i_set_min, i_set_hour,
               i_set_day, i_set_month, i_set_year,
`ifdef WATCH_ALARM_EN
        output i_alarm_en, i_alarm_hour, i_alarm_min, i_alarm_clr,
        input  o_alarm,
`endif
        input  o_sec_tick, o_set_err, o_sec, o_min, o_hour, o_day, o_month, o_year
    );

    modport slave (
        input  i_run_en, i_freq, i_set, i_set_sec, i_set_min, i_set_hour,
               i_set_day, i_set_month, i_set_year,
`ifdef WATCH_ALARM_EN
        input  i_alarm_en, i_alarm_hour, i_alarm_min, i_alarm_clr,
        output o_alarm,
`endif
        output o_sec_tick, o_set_err, o_sec, o_min, o_hour, o_day, o_month, o_year
    );
endinterface

// File: rtl/watch_calendar_core.sv
// rtl/watch_calendar_core.sv - one-second prescaler plus single-cycle calendar with leap years and time-set
// Optional sticky alarm compiled in with WATCH_ALARM_EN.
module watch_calendar_core #(
    parameter int P_COUNT_BIT = 30,
    parameter int P_YEAR_BIT  = 7,
    parameter int P_YEAR_MAX  = 99
) (
    input  logic                 clk,
    input  logic                 reset,
    watch_calendar_core_if.slave bus
);
    localparam logic [P_YEAR_BIT-1:0]  L_YEAR_MAX = P_YEAR_BIT'(P_YEAR_MAX);
    localparam logic [P_COUNT_BIT-1:0] L_ONE      = P_COUNT_BIT'(1);

    logic [P_COUNT_BIT-1:0] r_count;
    logic [5:0]             r_sec;
    logic [5:0]             r_min;
    logic [4:0]             r_hour;
    logic [4:0]             r_day;
    logic [3:0]             r_month;
    logic [P_YEAR_BIT-1:0]  r_year;
    logic                   r_tick;
    logic                   r_set_err;

    logic                   w_tick;
    logic [4:0]             w_cur_len;
    logic [4:0]             w_set_len;
    logic                   w_set_valid;
    logic                   w_set_ok;
    logic                   w_c_min;
    logic                   w_c_hour;
    logic                   w_c_day;
    logic                   w_c_month;
    logic                   w_c_year;
    logic [5:0]             w_sec_nxt;
    logic [5:0]             w_min_nxt;
    logic [4:0]             w_hour_nxt;
    logic [4:0]             w_day_nxt;
    logic [3:0]             w_month_nxt;
    logic [P_YEAR_BIT-1:0]  w_year_nxt;

    // Leap rule is year[1:0]==0, valid across the 2000-based 0..99 range
    function automatic logic [4:0] f_month_len(input logic [3:0] month, input logic leap);
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: f_month_len = 5'd30;
            4'd2:                    f_month_len = leap ? 5'd29 : 5'd28;
            default:                 f_month_len = 5'd31;
        endcase
    endfunction

    // A count at or past a newly lowered i_freq-1 also counts as terminal
    assign w_tick = bus.i_run_en &&
                    ((bus.i_freq <= L_ONE) || (r_count >= (bus.i_freq - L_ONE)));

    assign w_cur_len = f_month_len(r_month, r_year[1:0] == 2'd0);
    assign w_set_len = f_month_len(bus.i_set_month, bus.i_set_year[1:0] == 2'd0);

    assign w_set_valid = (bus.i_set_sec <= 6'd59) && (bus.i_set_min <= 6'd59) &&
                         (bus.i_set_hour <= 5'd23) &&
                         (bus.i_set_month >= 4'd1) && (bus.i_set_month <= 4'd12) &&
                         (bus.i_set_day >= 5'd1) && (bus.i_set_day <= w_set_len) &&
                         (bus.i_set_year <= L_YEAR_MAX);
    assign w_set_ok = bus.i_set && w_set_valid;

    assign w_c_min   = (r_sec == 6'd59);
    assign w_c_hour  = w_c_min && (r_min == 6'd59);
    assign w_c_day   = w_c_hour && (r_hour == 5'd23);
    assign w_c_month = w_c_day && (r_day == w_cur_len);
    assign w_c_year  = w_c_month && (r_month == 4'd12);

    assign w_sec_nxt   = w_c_min ? 6'd0 : r_sec + 6'd1;
    assign w_min_nxt   = !w_c_min ? r_min : (w_c_hour ? 6'd0 : r_min + 6'd1);
    assign w_hour_nxt  = !w_c_hour ? r_hour : (w_c_day ? 5'd0 : r_hour + 5'd1);
    assign w_day_nxt   = !w_c_day ? r_day : (w_c_month ? 5'd1 : r_day + 5'd1);
    assign w_month_nxt = !w_c_month ? r_month : (w_c_year ? 4'd1 : r_month + 4'd1);
    assign w_year_nxt  = !w_c_year ? r_year :
                         ((r_year >= L_YEAR_MAX) ? '0 : r_year + P_YEAR_BIT'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_sec     <= 6'd0;
            r_min     <= 6'd0;
            r_hour    <= 5'd0;
            r_day     <= 5'd1;
            r_month   <= 4'd1;
            r_year    <= '0;
            r_tick    <= 1'b0;
            r_set_err <= 1'b0;
        end else begin
            r_set_err <= bus.i_set && !w_set_valid;
            r_tick    <= w_tick && !w_set_ok;
            if (w_set_ok) begin
                r_count <= '0;
                r_sec   <= bus.i_set_sec;
                r_min   <= bus.i_set_min;
                r_hour  <= bus.i_set_hour;
                r_day   <= bus.i_set_day;
                r_month <= bus.i_set_month;
                r_year  <= bus.i_set_year;
            end else if (w_tick) begin
                r_count <= '0;
                r_sec   <= w_sec_nxt;
                r_min   <= w_min_nxt;
                r_hour  <= w_hour_nxt;
                r_day   <= w_day_nxt;
                r_month <= w_month_nxt;
                r_year  <= w_year_nxt;
            end else if (bus.i_run_en) begin
                r_count <= r_count + L_ONE;
            end
        end
    end

`ifdef WATCH_ALARM_EN
    logic r_alarm;
    logic w_alarm_hit;

    // Only a real tick landing on hh:mm:00 raises it; time-set never does
    assign w_alarm_hit = w_tick && !w_set_ok && bus.i_alarm_en &&
                         (w_hour_nxt == bus.i_alarm_hour) &&
                         (w_min_nxt == bus.i_alarm_min) && (w_sec_nxt == 6'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alarm <= 1'b0;
        end else if (w_alarm_hit) begin
            r_alarm <= 1'b1;
        end else if (bus.i_alarm_clr) begin
            r_alarm <= 1'b0;
        end
    end

    assign bus.o_alarm = r_alarm;
`endif

    assign bus.o_sec_tick = r_tick;
    assign bus.o_set_err  = r_set_err;
    assign bus.o_sec      = r_sec;
    assign bus.o_min      = r_min;
    assign bus.o_hour     = r_hour;
    assign bus.o_day      = r_day;
    assign bus.o_month    = r_month;
    assign bus.o_year     = r_year;
endmodule

// File: tb/tb_watch_calendar_core.sv
// tb/tb_watch_calendar_core.sv - self-checking bench for watch_calendar_core
// Alarm checks are included when WATCH_ALARM_EN is defined.
module tb_watch_calendar_core;
    logic clk = 1'b0;
    logic reset;

    watch_calendar_core_if #(.P_COUNT_BIT(30), .P_YEAR_BIT(7)) bus ();

    watch_calendar_core #(.P_COUNT_BIT(30), .P_YEAR_BIT(7), .P_YEAR_MAX(99)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sec, min, hour, day, month, year;
        int err;
    } exp_t;

    typedef struct {
        int sec, min, hour, day, month, year;
        bit ok;
        int esec, emin, ehour, eday, emonth, eyear;
    } vec_t;

    exp_t sb[$];
    vec_t vtab[15];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_set(input int s, input int m, input int h, input int d,
                             input int mo, input int y);
        bus.i_set_sec   = 6'(s);
        bus.i_set_min   = 6'(m);
        bus.i_set_hour  = 5'(h);
        bus.i_set_day   = 5'(d);
        bus.i_set_month = 4'(mo);
        bus.i_set_year  = 7'(y);
        bus.i_set       = 1'b1;
        step();
        bus.i_set       = 1'b0;
    endtask

    task automatic check_fields(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_sec"},   int'(bus.o_sec),   e.sec);
            chk({tag, "_min"},   int'(bus.o_min),   e.min);
            chk({tag, "_hour"},  int'(bus.o_hour),  e.hour);
            chk({tag, "_day"},   int'(bus.o_day),   e.day);
            chk({tag, "_month"}, int'(bus.o_month), e.month);
            chk({tag, "_year"},  int'(bus.o_year),  e.year);
            chk({tag, "_err"},   int'(bus.o_set_err), e.err);
        end
    endtask

    task automatic wait_tick(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        for (int n = 1; n <= 16; n++) begin
            step();
            if (bus.o_sec_tick) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_tick_latency"}, lat, exp_lat);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sec"},   int'(bus.o_sec),   0);
        chk({tag, "_min"},   int'(bus.o_min),   0);
        chk({tag, "_hour"},  int'(bus.o_hour),  0);
        chk({tag, "_day"},   int'(bus.o_day),   1);
        chk({tag, "_month"}, int'(bus.o_month), 1);
        chk({tag, "_year"},  int'(bus.o_year),  0);
        chk({tag, "_tick"},  int'(bus.o_sec_tick), 0);
        chk({tag, "_err"},   int'(bus.o_set_err),  0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vtab[0]  = '{59, 59, 23, 31, 12,  5, 1'b1,  0,  0,  0,  1,  1,  6};
        vtab[1]  = '{59, 59, 23, 31, 12, 99, 1'b1,  0,  0,  0,  1,  1,  0};
        vtab[2]  = '{59, 59, 23, 28,  2,  4, 1'b1,  0,  0,  0, 29,  2,  4};
        vtab[3]  = '{59, 59, 23, 28,  2,  5, 1'b1,  0,  0,  0,  1,  3,  5};
        vtab[4]  = '{59, 59, 23, 29,  2,  4, 1'b1,  0,  0,  0,  1,  3,  4};
        vtab[5]  = '{30, 20, 10, 15,  6,  7, 1'b1, 31, 20, 10, 15,  6,  7};
        vtab[6]  = '{59, 59, 12, 30,  4,  1, 1'b1,  0,  0, 13, 30,  4,  1};
        vtab[7]  = '{59, 59, 23, 30,  4,  1, 1'b1,  0,  0,  0,  1,  5,  1};
        vtab[8]  = '{ 0,  0,  0, 31,  4,  1, 1'b0,  0,  0,  0,  0,  0,  0};
        vtab[9]  = '{ 0,  0, 24, 10,  4,  1, 1'b0,  0,  0,  0,  0,  0,  0};
        vtab[10] = '{ 0,  0,  0, 29,  2,  5, 1'b0,  0,  0,  0,  0,  0,  0};
        vtab[11] = '{ 0,  0,  0,  1, 13,  1, 1'b0,  0,  0,  0,  0,  0,  0};
        vtab[12] = '{ 0,  0,  0,  1,  0,  1, 1'b0,  0,  0,  0,  0,  0,  0};
        vtab[13] = '{60,  0,  0,  1,  1,  1, 1'b0,  0,  0,  0,  0,  0,  0};
        vtab[14] = '{ 0,  0,  0,  1,  1,100, 1'b0,  0,  0,  0,  0,  0,  0};

        reset           = 1'b1;
        bus.i_run_en    = 1'b0;
        bus.i_freq      = 30'd4;
        bus.i_set       = 1'b0;
        bus.i_set_sec   = '0;
        bus.i_set_min   = '0;
        bus.i_set_hour  = '0;
        bus.i_set_day   = '0;
        bus.i_set_month = '0;
        bus.i_set_year  = '0;
`ifdef WATCH_ALARM_EN
        bus.i_alarm_en   = 1'b1;
        bus.i_alarm_hour = 5'd0;
        bus.i_alarm_min  = 6'd1;
        bus.i_alarm_clr  = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        check_reset_vals("reset");

        // Free run at 4 clk per second through the first minute rollover
        bus.i_run_en = 1'b1;
        for (int k = 1; k <= 240; k++) begin
            step();
            chk($sformatf("run_tick_%0d", k), int'(bus.o_sec_tick), (k % 4 == 0) ? 1 : 0);
            chk($sformatf("run_sec_%0d", k), int'(bus.o_sec), (k / 4) % 60);
`ifdef WATCH_ALARM_EN
            chk($sformatf("alarm_%0d", k), int'(bus.o_alarm), (k >= 240) ? 1 : 0);
`endif
        end
        chk("run_min_after_240", int'(bus.o_min), 1);

`ifdef WATCH_ALARM_EN
        bus.i_run_en = 1'b0;
        step();
        step();
        chk("alarm_sticky", int'(bus.o_alarm), 1);
        bus.i_alarm_clr = 1'b1;
        step();
        bus.i_alarm_clr = 1'b0;
        chk("alarm_cleared", int'(bus.o_alarm), 0);
        bus.i_alarm_en = 1'b0;
        drive_set(59, 0, 0, 1, 1, 0);
        bus.i_run_en = 1'b1;
        wait_tick("alarm_dis", 4);
        chk("alarm_dis_never", int'(bus.o_alarm), 0);
`endif

        // Freeze holds everything
        bus.i_run_en = 1'b0;
        begin
            int sec_before;
            int ticks;
            sec_before = int'(bus.o_sec);
            ticks = 0;
            for (int k = 0; k < 10; k++) begin
                step();
                ticks += int'(bus.o_sec_tick);
            end
            chk("freeze_ticks", ticks, 0);
            chk("freeze_sec", int'(bus.o_sec), sec_before);
        end

        // Table of set vectors, each followed by one tick for valid entries
        for (int i = 0; i < 15; i++) begin
            bus.i_run_en = 1'b0;
            if (vtab[i].ok) begin
                sb.push_back('{vtab[i].sec, vtab[i].min, vtab[i].hour, vtab[i].day,
                               vtab[i].month, vtab[i].year, 0});
                drive_set(vtab[i].sec, vtab[i].min, vtab[i].hour, vtab[i].day,
                          vtab[i].month, vtab[i].year);
                check_fields($sformatf("v%0d_set", i));
                sb.push_back('{vtab[i].esec, vtab[i].emin, vtab[i].ehour, vtab[i].eday,
                               vtab[i].emonth, vtab[i].eyear, 0});
                bus.i_run_en = 1'b1;
                wait_tick($sformatf("v%0d", i), 4);
                bus.i_run_en = 1'b0;
                check_fields($sformatf("v%0d_tick", i));
            end else begin
                sb.push_back('{30, 20, 10, 15, 6, 7, 0});
                drive_set(30, 20, 10, 15, 6, 7);
                check_fields($sformatf("v%0d_base", i));
                sb.push_back('{30, 20, 10, 15, 6, 7, 1});
                drive_set(vtab[i].sec, vtab[i].min, vtab[i].hour, vtab[i].day,
                          vtab[i].month, vtab[i].year);
                check_fields($sformatf("v%0d_bad", i));
                step();
                chk($sformatf("v%0d_err_pulse_end", i), int'(bus.o_set_err), 0);
            end
        end

        // Lowering i_freq below the current count forces an immediate wrap
        do_reset();
        bus.i_freq   = 30'd8;
        bus.i_run_en = 1'b1;
        begin
            int ticks;
            ticks = 0;
            for (int k = 0; k < 6; k++) begin
                step();
                ticks += int'(bus.o_sec_tick);
            end
            chk("freq8_no_tick", ticks, 0);
        end
        bus.i_freq = 30'd4;
        step();
        chk("freq_lower_tick", int'(bus.o_sec_tick), 1);
        chk("freq_lower_sec", int'(bus.o_sec), 1);

        // Set on the terminal cycle wins over the tick
        do_reset();
        bus.i_run_en = 1'b1;
        wait_tick("pre_term", 4);
        step();
        step();
        step();
        sb.push_back('{56, 34, 12, 10, 10, 10, 0});
        drive_set(56, 34, 12, 10, 10, 10);
        chk("term_set_no_tick", int'(bus.o_sec_tick), 0);
        check_fields("term_set");
        sb.push_back('{57, 34, 12, 10, 10, 10, 0});
        wait_tick("term_next", 4);
        check_fields("term_next");

        // Async reset mid-count clears outputs without a clock edge
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_reset");
        step();
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
